// File: rtl/mult_datapath.sv
// Register/arithmetic datapath for the two's-complement shift-add multiplier.
// Holds {X, A, B}; strobes from the control FSM select load, clear, add/sub and shift.
module mult_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Switches,
  input  logic             Clr_Ld,
  input  logic             Clear,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift_En,
  output logic             M,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval
);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   a_ext, s_ext, arith;

  assign a_ext = {a_q[WIDTH-1], a_q};
  assign s_ext = {Switches[WIDTH-1], Switches};

  // Without Add/Sub the shift works on the current {X, A}, which may differ from sext(A).
  always_comb begin
    arith = {x_q, a_q};
    if (Sub) begin
      arith = a_ext - s_ext;
    end else if (Add) begin
      arith = a_ext + s_ext;
    end
  end

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    if (Clr_Ld) begin
      x_d = 1'b0;
      a_d = '0;
      b_d = Switches;
    end else if (Clear) begin
      x_d = 1'b0;
      a_d = '0;
    end else begin
      x_d = arith[WIDTH];
      a_d = arith[WIDTH-1:0];
      if (Shift_En) begin
        a_d = arith[WIDTH:1];
        b_d = {arith[0], b_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign M    = b_q[0];
  assign X    = x_q;
  assign Aval = a_q;
  assign Bval = b_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: integer-level model of {X,A,B}, per-cycle compare,
// directed literal cases and randomized strobes/multiplies.
module tb_mult_datapath;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Switches = 8'h00;
  logic       Clr_Ld = 1'b0, Clear = 1'b0, Add = 1'b0, Sub = 1'b0, Shift_En = 1'b0;
  logic       M, X;
  logic [7:0] Aval, Bval;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Model state: xa is the signed value of {X,A}, b the unsigned value of B.
  int m_xa = 0;
  int m_b  = 0;
  int nxa, nb;

  mult_datapath #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Switches (Switches),
    .Clr_Ld   (Clr_Ld),
    .Clear    (Clear),
    .Add      (Add),
    .Sub      (Sub),
    .Shift_En (Shift_En),
    .M        (M),
    .X        (X),
    .Aval     (Aval),
    .Bval     (Bval)
  );

  always #5 Clk = ~Clk;

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic void model_next(input int xa, input int b, input logic cl, input logic clr,
                                     input logic ad, input logic su, input logic sh,
                                     input int sw, output int oxa, output int ob);
    int full;
    oxa = xa;
    ob  = b;
    if (cl) begin
      oxa = 0;
      ob  = sw;
    end else if (clr) begin
      oxa = 0;
    end else begin
      if (su) oxa = sx8(xa & 255) - sx8(sw);
      else if (ad) oxa = sx8(xa & 255) + sx8(sw);
      if (sh) begin
        full = oxa * 256 + ob;
        full = full >>> 1;
        oxa  = full >>> 8;
        ob   = full & 255;
      end
    end
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_xa <= 0;
      m_b  <= 0;
    end else begin
      model_next(m_xa, m_b, Clr_Ld, Clear, Add, Sub, Shift_En, int'(Switches), nxa, nb);
      m_xa <= nxa;
      m_b  <= nb;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge Clk) begin
    if (checking) begin
      chk("model X", int'(X), (m_xa >> 8) & 1);
      chk("model A", int'(Aval), m_xa & 255);
      chk("model B", int'(Bval), m_b);
      chk("model M", int'(M), m_b & 1);
    end
  end

  task automatic cyc(input logic cl, input logic clr, input logic ad, input logic su,
                     input logic sh, input logic [7:0] sw);
    Clr_Ld = cl; Clear = clr; Add = ad; Sub = su; Shift_En = sh; Switches = sw;
    @(posedge Clk);
    #2;
    Clr_Ld = 1'b0; Clear = 1'b0; Add = 1'b0; Sub = 1'b0; Shift_En = 1'b0;
  endtask

  task automatic do_mult(input logic [7:0] mr, input logic [7:0] md);
    logic mm;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mr);
    for (int i = 1; i <= 8; i++) begin
      mm = m_b[0];
      cyc(1'b0, 1'b0, mm && (i < 8), mm && (i == 8), 1'b1, md);
    end
  endtask

  task automatic chk_state(input string name, input int ex, input int ea, input int eb);
    chk({name, " X"}, int'(X), ex);
    chk({name, " A"}, int'(Aval), ea);
    chk({name, " B"}, int'(Bval), eb);
  endtask

  initial begin
    logic signed [16:0] prod;
    logic [7:0] r1, r2;
    int expp;

    #3;
    chk("reset X", int'(X), 0);
    chk("reset M", int'(M), 0);
    checking = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;

    // Asynchronous reset between edges.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    chk("load A5 B", int'(Bval), 'hA5);
    Reset_n = 1'b0;
    #1;
    chk_state("async reset", 0, 0, 0);
    chk("async reset M", int'(M), 0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;

    // Load then clear.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD);
    chk_state("load FD", 0, 0, 'hFD);
    chk("load FD M", int'(M), 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    chk_state("clear", 0, 0, 'hFD);

    // 7 x -3 = -21.
    do_mult(8'hFD, 8'h07);
    chk_state("7x-3", 1, 'hFF, 'hEB);

    // -128 x -128 = 16384.
    do_mult(8'h80, 8'h80);
    chk_state("-128x-128", 0, 'h40, 'h00);

    // Shift only from X=1 A=0x80 B=0x01.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    chk_state("setup shift", 1, 'h80, 'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    chk_state("shift only", 1, 'hC0, 'h00);
    chk("shift only M", int'(M), 0);

    // Add and Sub together: Sub wins.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
    chk("setup A=5", int'(Aval), 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    chk("add+sub X", int'(X), 0);
    chk("add+sub A", int'(Aval), 2);

    // Clr_Ld masks arithmetic and shift.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12);
    chk_state("priority", 0, 0, 'h12);

    // Random multiplies: {X,A,B} must equal the signed product.
    for (int k = 0; k < 30; k++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      if (k == 0) r1 = 8'h7F;
      if (k == 1) r2 = 8'h80;
      do_mult(r1, r2);
      prod = {X, Aval, Bval};
      expp = sx8(int'(r1)) * sx8(int'(r2));
      chk("random product", int'(prod), expp);
    end

    // Random strobe soup.
    for (int k = 0; k < 300; k++) begin
      cyc(($urandom % 16) == 0, ($urandom % 16) == 0, 1'($urandom), 1'($urandom),
          1'($urandom), 8'($urandom));
    end

    // Reset mid-multiply aborts.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB7);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6D);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6D);
    Reset_n = 1'b0;
    #1;
    chk_state("mid reset", 0, 0, 0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    do_mult(8'hFD, 8'h07);
    chk_state("after reset 7x-3", 1, 'hFF, 'hEB);

    @(negedge Clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
